// File: rtl/max_pool_layer_1.sv
// 2x2 stride-2 binary max-pool (per-channel OR) over an 8-channel raster stream.
// Optional MAX_POOL_LAYER_1_FRAME_DONE_EN adds frame_done_pool1 and a saturating frame counter.
module max_pool_layer_1 #(
    parameter int WIDTH  = 26,
    parameter int HEIGHT = 26
) (
    input  logic clk,
    input  logic rst,
    input  logic conv1_out_1,
    input  logic conv1_out_2,
    input  logic conv1_out_3,
    input  logic conv1_out_4,
    input  logic conv1_out_5,
    input  logic conv1_out_6,
    input  logic conv1_out_7,
    input  logic conv1_out_8,
    input  logic valid_out_conv1,
    output logic pool1_out_1,
    output logic pool1_out_2,
    output logic pool1_out_3,
    output logic pool1_out_4,
    output logic pool1_out_5,
    output logic pool1_out_6,
    output logic pool1_out_7,
    output logic pool1_out_8,
    output logic valid_out_pool1
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
    ,
    output logic frame_done_pool1
`endif
);

    localparam int CW  = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
    localparam int RW  = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int LB  = WIDTH / 2;
    localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

    localparam logic [CW-1:0] COL_LAST     = CW'(WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST     = RW'(HEIGHT - 1);
    localparam logic [CW-1:0] COL_LAST_WIN = CW'(2 * (WIDTH / 2) - 1);
    localparam logic [RW-1:0] ROW_LAST_WIN = RW'(2 * (HEIGHT / 2) - 1);

    logic [CW-1:0]  col_cnt;
    logic [RW-1:0]  row_cnt;
    logic [7:0]     hold;
    logic [7:0]     linebuf [LB];
    logic [7:0]     pool;
    logic [7:0]     pix;
    logic [LBW-1:0] lb_idx;

    assign pix = {conv1_out_8, conv1_out_7, conv1_out_6, conv1_out_5,
                  conv1_out_4, conv1_out_3, conv1_out_2, conv1_out_1};

    // Only odd columns address the line buffer, so c>>1 always stays below LB.
    assign lb_idx = col_cnt[LBW:1];

    assign {pool1_out_8, pool1_out_7, pool1_out_6, pool1_out_5,
            pool1_out_4, pool1_out_3, pool1_out_2, pool1_out_1} = pool;

`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
    logic [15:0] frame_cnt;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            col_cnt         <= '0;
            row_cnt         <= '0;
            hold            <= '0;
            pool            <= '0;
            valid_out_pool1 <= 1'b0;
            for (int unsigned i = 0; i < LB; i++) begin
                linebuf[i] <= '0;
            end
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
            frame_done_pool1 <= 1'b0;
            frame_cnt        <= '0;
`endif
        end else begin
            valid_out_pool1 <= 1'b0;
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
            frame_done_pool1 <= 1'b0;
`endif
            if (valid_out_conv1) begin
                if (col_cnt == COL_LAST) begin
                    col_cnt <= '0;
                    row_cnt <= (row_cnt == ROW_LAST) ? '0 : row_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end

                // Trailing odd column/row land in the even branches and never emit.
                if (!col_cnt[0]) begin
                    hold <= pix;
                end else if (!row_cnt[0]) begin
                    linebuf[lb_idx] <= hold | pix;
                end else begin
                    pool            <= linebuf[lb_idx] | hold | pix;
                    valid_out_pool1 <= 1'b1;
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
                    if (row_cnt == ROW_LAST_WIN && col_cnt == COL_LAST_WIN) begin
                        frame_done_pool1 <= 1'b1;
                        if (frame_cnt != 16'hFFFF) begin
                            frame_cnt <= frame_cnt + 16'd1;
                        end
                    end
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_max_pool_layer_1.sv
// Self-checking bench for max_pool_layer_1: random/directed frames against a 2x2 OR reference.
module tb_max_pool_layer_1;

    localparam int W    = 26;
    localparam int H    = 26;
    localparam int WO   = W / 2;
    localparam int HO   = H / 2;
    localparam int NWIN = WO * HO;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] din;
    logic       vin;
    logic [7:0] pout;
    logic       pvalid;
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
    logic       fdone;
`endif

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [7:0] frame   [H][W];
    logic [7:0] exp_win [NWIN];
    logic [7:0] exp_a   [NWIN];
    logic [7:0] got_q   [$];
    int         got_cyc [$];
    logic [7:0] ref_q   [$];
    int         fd_idx  [$];

    max_pool_layer_1 #(.WIDTH(W), .HEIGHT(H)) dut (
        .clk             (clk),
        .rst             (rst),
        .conv1_out_1     (din[0]),
        .conv1_out_2     (din[1]),
        .conv1_out_3     (din[2]),
        .conv1_out_4     (din[3]),
        .conv1_out_5     (din[4]),
        .conv1_out_6     (din[5]),
        .conv1_out_7     (din[6]),
        .conv1_out_8     (din[7]),
        .valid_out_conv1 (vin),
        .pool1_out_1     (pout[0]),
        .pool1_out_2     (pout[1]),
        .pool1_out_3     (pout[2]),
        .pool1_out_4     (pout[3]),
        .pool1_out_5     (pout[4]),
        .pool1_out_6     (pout[5]),
        .pool1_out_7     (pout[6]),
        .pool1_out_8     (pout[7]),
        .valid_out_pool1 (pvalid)
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
        ,
        .frame_done_pool1(fdone)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pvalid) begin
            got_q.push_back(pout);
            got_cyc.push_back(cyc);
        end
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
        if (fdone) fd_idx.push_back(got_q.size());
`endif
    end

    // Reference: each output is the OR of its 2x2 input window, in raster order.
    function automatic void build_expected();
        for (int wr = 0; wr < HO; wr++)
            for (int wc = 0; wc < WO; wc++)
                exp_win[wr*WO+wc] = frame[2*wr][2*wc]   | frame[2*wr][2*wc+1] |
                                    frame[2*wr+1][2*wc] | frame[2*wr+1][2*wc+1];
    endfunction

    function automatic void fill_frame(input int mode);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = (mode == 0) ? 8'h00 : (mode == 1) ? 8'hFF : 8'($urandom);
    endfunction

    function automatic logic [7:0] got_at(input int i);
        return (i < got_q.size()) ? got_q[i] : 8'hxx;
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            vin = 1'b0;
            din = 8'($urandom);
        end
    endtask

    task automatic send_frame(input int gap, output int c27);
        c27 = -1;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++) begin
                if (gap > 0)
                    while ($urandom_range(99) < gap) idle(1);
                @(posedge clk); #1;
                vin = 1'b1;
                din = frame[r][c];
                if (r == 1 && c == 1) c27 = cyc + 1;
            end
    endtask

    task automatic clear_obs();
        got_q.delete();
        got_cyc.delete();
        fd_idx.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; vin = 1'b0; din = 8'h00;
        idle(3);
        checks++;
        if (pvalid !== 1'b0) begin
            failures++; $display("FAIL reset_valid got=%b exp=0", pvalid);
        end
        checks++;
        if (pout !== 8'h00) begin
            failures++; $display("FAIL reset_out got=%h exp=00", pout);
        end
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
        checks++;
        if (fdone !== 1'b0) begin
            failures++; $display("FAIL reset_frame_done got=%b exp=0", fdone);
        end
`endif
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_all_zero();
        int c27;
        fill_frame(0);
        clear_obs();
        send_frame(0, c27);
        idle(3);
        checks++;
        if (got_q.size() !== NWIN) begin
            failures++; $display("FAIL zero_count got=%0d exp=%0d", got_q.size(), NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            checks++;
            if (got_at(i) !== 8'h00) begin
                failures++; $display("FAIL zero_win%0d got=%h exp=00", i, got_at(i));
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] !== c27) begin
            failures++;
            $display("FAIL zero_latency got=%0d exp=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0], c27);
        end
    endtask

    task automatic test_single_hot();
        int c27;
        fill_frame(0);
        frame[5][8] = 8'h04;
        build_expected();
        clear_obs();
        send_frame(0, c27);
        idle(3);
        checks++;
        if (got_q.size() !== NWIN) begin
            failures++; $display("FAIL hot_count got=%0d exp=%0d", got_q.size(), NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            checks++;
            if (got_at(i) !== exp_win[i]) begin
                failures++; $display("FAIL hot_win%0d got=%h exp=%h", i, got_at(i), exp_win[i]);
            end
        end
        checks++;
        if (got_at(30) !== 8'h04) begin
            failures++; $display("FAIL hot_win30_direct got=%h exp=04", got_at(30));
        end
        ref_q = got_q;
    endtask

    task automatic test_corners();
        int c27;
        fill_frame(0);
        for (int i = 0; i < NWIN; i++)
            frame[2*(i/WO) + (i%4)/2][2*(i%WO) + (i%4)%2] = 8'h01;
        clear_obs();
        send_frame(0, c27);
        idle(3);
        checks++;
        if (got_q.size() !== NWIN) begin
            failures++; $display("FAIL corner_count got=%0d exp=%0d", got_q.size(), NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            checks++;
            if (got_at(i) !== 8'h01) begin
                failures++; $display("FAIL corner_win%0d got=%h exp=01", i, got_at(i));
            end
        end
    endtask

    task automatic test_gapped();
        int c27;
        fill_frame(0);
        frame[5][8] = 8'h04;
        clear_obs();
        send_frame(50, c27);
        idle(3);
        checks++;
        if (got_q.size() !== ref_q.size()) begin
            failures++; $display("FAIL gap_count got=%0d exp=%0d", got_q.size(), ref_q.size());
        end
        for (int i = 0; i < ref_q.size(); i++) begin
            checks++;
            if (got_at(i) !== ref_q[i]) begin
                failures++; $display("FAIL gap_win%0d got=%h exp=%h", i, got_at(i), ref_q[i]);
            end
        end
    endtask

    task automatic test_random();
        int c27;
        for (int f = 0; f < 2; f++) begin
            fill_frame(2);
            build_expected();
            clear_obs();
            send_frame(30, c27);
            idle(3);
            checks++;
            if (got_q.size() !== NWIN) begin
                failures++; $display("FAIL rand%0d_count got=%0d exp=%0d", f, got_q.size(), NWIN);
            end
            for (int i = 0; i < NWIN; i++) begin
                checks++;
                if (got_at(i) !== exp_win[i]) begin
                    failures++; $display("FAIL rand%0d_win%0d got=%h exp=%h", f, i, got_at(i), exp_win[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        int c27;
        fill_frame(2);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            vin = 1'b1;
            din = frame[k/W][k%W];
        end
        @(posedge clk); #1;
        vin = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (pvalid !== 1'b0) begin
            failures++; $display("FAIL midrst_valid got=%b exp=0", pvalid);
        end
        checks++;
        if (pout !== 8'h00) begin
            failures++; $display("FAIL midrst_out got=%h exp=00", pout);
        end
        fill_frame(1);
        clear_obs();
        send_frame(0, c27);
        idle(3);
        checks++;
        if (got_q.size() !== NWIN) begin
            failures++; $display("FAIL midrst_count got=%0d exp=%0d", got_q.size(), NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            checks++;
            if (got_at(i) !== 8'hFF) begin
                failures++; $display("FAIL midrst_win%0d got=%h exp=ff", i, got_at(i));
            end
        end
        checks++;
        if (got_cyc.size() == 0 || got_cyc[0] !== c27) begin
            failures++;
            $display("FAIL midrst_latency got=%0d exp=%0d", (got_cyc.size() == 0) ? -1 : got_cyc[0], c27);
        end
    endtask

    task automatic test_back_to_back();
        int c27;
        fill_frame(2);
        build_expected();
        exp_a = exp_win;
        clear_obs();
        send_frame(0, c27);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                frame[r][c] = ~frame[r][c];
        build_expected();
        send_frame(0, c27);
        idle(3);
        checks++;
        if (got_q.size() !== 2 * NWIN) begin
            failures++; $display("FAIL b2b_count got=%0d exp=%0d", got_q.size(), 2 * NWIN);
        end
        for (int i = 0; i < NWIN; i++) begin
            checks++;
            if (got_at(i) !== exp_a[i]) begin
                failures++; $display("FAIL b2b_a_win%0d got=%h exp=%h", i, got_at(i), exp_a[i]);
            end
            checks++;
            if (got_at(NWIN + i) !== exp_win[i]) begin
                failures++; $display("FAIL b2b_b_win%0d got=%h exp=%h", i, got_at(NWIN + i), exp_win[i]);
            end
        end
`ifdef MAX_POOL_LAYER_1_FRAME_DONE_EN
        checks++;
        if (fd_idx.size() !== 2 || fd_idx[0] !== NWIN || fd_idx[1] !== 2 * NWIN) begin
            failures++;
            $display("FAIL b2b_frame_done got=%0d pulses first=%0d exp=2 pulses at %0d,%0d",
                     fd_idx.size(), (fd_idx.size() > 0) ? fd_idx[0] : -1, NWIN, 2 * NWIN);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_all_zero();
        test_single_hot();
        test_corners();
        test_gapped();
        test_random();
        test_reset_mid_frame();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
